// File: rtl/jtag_tap_ctrl_if.sv
// JTAG TAP pin and debug-side signal bundle.
// master: board pins / debug logic driving the TAP; slave: the TAP controller.
interface jtag_tap_ctrl_if #(
  parameter int unsigned IR_WIDTH = 4,
  parameter int unsigned DR_WIDTH = 32
);
  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                tdo_en;
  logic [3:0]          state;
  logic [IR_WIDTH-1:0] ir;
  logic [DR_WIDTH-1:0] dr_capture_data;
  logic [DR_WIDTH-1:0] dr_update_data;
  logic                dr_update;
  logic                ir_update;

  modport master (
    output tms, tdi, dr_capture_data,
    input  tdo, tdo_en, state, ir, dr_update_data, dr_update, ir_update
  );

  modport slave (
    input  tms, tdi, dr_capture_data,
    output tdo, tdo_en, state, ir, dr_update_data, dr_update, ir_update
  );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller with IR, IDCODE, BYPASS and USER data registers.
// Optional macro JTAG_TRST_EN adds a synchronous active-high trst input.
module jtag_tap_ctrl #(
  parameter int unsigned         IR_WIDTH  = 4,
  parameter int unsigned         DR_WIDTH  = 32,
  parameter logic [31:0]         IDCODE    = 32'h1234_5679,
  parameter logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(8)
) (
  input logic CLK,
  input logic RESET,
`ifdef JTAG_TRST_EN
  input logic trst,
`endif
  jtag_tap_ctrl_if.slave tap
);

  localparam int unsigned IDW = 32;

  typedef enum logic [3:0] {
    EX2_DR = 4'd0,  EX1_DR = 4'd1,  SH_DR  = 4'd2,  PAU_DR = 4'd3,
    SEL_IR = 4'd4,  UPD_DR = 4'd5,  CAP_DR = 4'd6,  SEL_DR = 4'd7,
    EX2_IR = 4'd8,  EX1_IR = 4'd9,  SH_IR  = 4'd10, PAU_IR = 4'd11,
    RTI    = 4'd12, UPD_IR = 4'd13, CAP_IR = 4'd14, TLR    = 4'd15
  } tap_state_e;

  tap_state_e          state_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IDW-1:0]      idcode_shift;
  logic [DR_WIDTH-1:0] user_shift;
  logic                bypass_shift;
  logic [DR_WIDTH-1:0] dr_update_data_q;
  logic                dr_update_q;
  logic                ir_update_q;
  logic                sel_idcode;
  logic                sel_user;
  logic                trst_req;

`ifdef JTAG_TRST_EN
  assign trst_req = trst;
`else
  assign trst_req = 1'b0;
`endif

  // IDCODE wins if both opcodes are configured equal; everything else is BYPASS
  assign sel_idcode = (ir_q == IR_IDCODE);
  assign sel_user   = (ir_q == IR_USER) && !sel_idcode;

  function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PAU_DR;
      PAU_DR:  return tms ? EX2_DR : PAU_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PAU_IR;
      PAU_IR:  return tms ? EX2_IR : PAU_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      UPD_IR:  return tms ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  // State machine and register actions keyed on the state held before the edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q          <= TLR;
      ir_q             <= IR_IDCODE;
      ir_shift         <= '0;
      idcode_shift     <= '0;
      user_shift       <= '0;
      bypass_shift     <= 1'b0;
      dr_update_data_q <= '0;
      dr_update_q      <= 1'b0;
      ir_update_q      <= 1'b0;
    end else begin
      dr_update_q <= 1'b0;
      ir_update_q <= 1'b0;
      if (trst_req) begin
        state_q     <= TLR;
        ir_q        <= IR_IDCODE;
        ir_update_q <= (ir_q != IR_IDCODE);
      end else begin
        state_q <= next_state(state_q, tap.tms);
        case (state_q)
          TLR: begin
            ir_q        <= IR_IDCODE;
            ir_update_q <= (ir_q != IR_IDCODE);
          end
          CAP_IR: ir_shift <= IR_WIDTH'(2'b01);
          SH_IR:  ir_shift <= (ir_shift >> 1) | (IR_WIDTH'(tap.tdi) << (IR_WIDTH - 1));
          UPD_IR: begin
            ir_q        <= ir_shift;
            ir_update_q <= 1'b1;
          end
          CAP_DR: begin
            if (sel_idcode)    idcode_shift <= IDCODE;
            else if (sel_user) user_shift   <= tap.dr_capture_data;
            else               bypass_shift <= 1'b0;
          end
          SH_DR: begin
            if (sel_idcode)    idcode_shift <= {tap.tdi, idcode_shift[IDW-1:1]};
            else if (sel_user) user_shift   <= (user_shift >> 1) |
                                               (DR_WIDTH'(tap.tdi) << (DR_WIDTH - 1));
            else               bypass_shift <= tap.tdi;
          end
          UPD_DR: begin
            if (sel_user) begin
              dr_update_data_q <= user_shift;
              dr_update_q      <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tap.tdo_en = (state_q == SH_DR) || (state_q == SH_IR);

  // Serial output: LSB of whichever shift register is active, quiet otherwise
  always_comb begin
    tap.tdo = 1'b0;
    if (state_q == SH_IR)      tap.tdo = ir_shift[0];
    else if (state_q == SH_DR) tap.tdo = sel_idcode ? idcode_shift[0] :
                                         sel_user   ? user_shift[0]   : bypass_shift;
  end

  assign tap.state          = state_q;
  assign tap.ir             = ir_q;
  assign tap.dr_update_data = dr_update_data_q;
  assign tap.dr_update      = dr_update_q;
  assign tap.ir_update      = ir_update_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed self-checking bench for jtag_tap_ctrl.
module tb_jtag_tap_ctrl;
  logic CLK;
  logic RESET;
`ifdef JTAG_TRST_EN
  logic trst;
`endif
  int checks;
  int errors;

  jtag_tap_ctrl_if #(.IR_WIDTH(4), .DR_WIDTH(32)) tap ();

  jtag_tap_ctrl #(
    .IR_WIDTH(4), .DR_WIDTH(32), .IDCODE(32'h1234_5679),
    .IR_IDCODE(4'h1), .IR_USER(4'h8)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
`ifdef JTAG_TRST_EN
    .trst(trst),
`endif
    .tap(tap)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Drive one TCK-equivalent cycle; returns at the following falling edge
  task automatic step(input logic t, input logic d);
    tap.tms = t;
    tap.tdi = d;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // From RTI: load an opcode into the IR and return to RTI
  task automatic load_ir(input logic [3:0] op);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, op[i]);
    step(1, 0); step(0, 0);
  endtask

  // From RTI: full 32-bit DR scan, ends in RTI right after the update edge
  task automatic scan_dr(input logic [31:0] din, output logic [31:0] dout);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 32; i++) begin
      dout[i] = tap.tdo;
      step(i == 31, din[i]);
    end
    step(1, 0); step(0, 0);
  endtask

  task automatic test_reset;
    logic [3:0] exp_st [4] = '{4'd12, 4'd7, 4'd6, 4'd2};
    logic       tms_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    RESET = 1'b1;
    step(0, 0); step(0, 0);
    RESET = 1'b0;
    checks++; if (tap.state !== 4'd15) begin errors++; $display("FAIL reset_state: got %0d expected 15", tap.state); end
    checks++; if (tap.ir !== 4'h1) begin errors++; $display("FAIL reset_ir: got %h expected 1", tap.ir); end
    checks++; if (tap.dr_update_data !== 32'h0 || tap.dr_update !== 1'b0 || tap.ir_update !== 1'b0)
      begin errors++; $display("FAIL reset_outputs: got data=%h dru=%b iru=%b expected 0/0/0", tap.dr_update_data, tap.dr_update, tap.ir_update); end
    checks++; if (tap.tdo_en !== 1'b0 || tap.tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: got en=%b tdo=%b expected 0/0", tap.tdo_en, tap.tdo); end
    for (int i = 0; i < 4; i++) begin
      step(tms_seq[i], 0);
      checks++; if (tap.state !== exp_st[i]) begin errors++; $display("FAIL walk_state%0d: got %0d expected %0d", i, tap.state, exp_st[i]); end
    end
  endtask

  task automatic test_idcode;
    logic [31:0] dout;
    checks++; if (tap.tdo_en !== 1'b1) begin errors++; $display("FAIL idcode_tdo_en: got %b expected 1", tap.tdo_en); end
    for (int i = 0; i < 32; i++) begin
      dout[i] = tap.tdo;
      step(i == 31, 0);
    end
    checks++; if (dout !== 32'h1234_5679) begin errors++; $display("FAIL idcode_value: got %h expected 12345679", dout); end
    checks++; if (tap.state !== 4'd1) begin errors++; $display("FAIL idcode_ex1: got %0d expected 1", tap.state); end
    step(1, 0);
    checks++; if (tap.state !== 4'd5) begin errors++; $display("FAIL idcode_upd: got %0d expected 5", tap.state); end
    step(0, 0);
    checks++; if (tap.dr_update !== 1'b0 || tap.state !== 4'd12) begin errors++; $display("FAIL idcode_no_strobe: got dru=%b st=%0d expected 0/12", tap.dr_update, tap.state); end
  endtask

  task automatic test_ir_load;
    logic [3:0] dout;
    logic [3:0] din = 4'h8;
    step(1, 0); step(1, 0);
    checks++; if (tap.state !== 4'd4) begin errors++; $display("FAIL ir_sel_ir: got %0d expected 4", tap.state); end
    step(0, 0); step(0, 0);
    checks++; if (tap.state !== 4'd10) begin errors++; $display("FAIL ir_shift_state: got %0d expected 10", tap.state); end
    for (int i = 0; i < 4; i++) begin
      dout[i] = tap.tdo;
      step(i == 3, din[i]);
    end
    checks++; if (dout !== 4'b0001) begin errors++; $display("FAIL ir_capture_out: got %b expected 0001", dout); end
    checks++; if (tap.state !== 4'd9) begin errors++; $display("FAIL ir_ex1: got %0d expected 9", tap.state); end
    step(1, 0);
    checks++; if (tap.ir !== 4'h1 || tap.ir_update !== 1'b0) begin errors++; $display("FAIL ir_before_upd: got ir=%h iru=%b expected 1/0", tap.ir, tap.ir_update); end
    step(0, 0);
    checks++; if (tap.ir !== 4'h8 || tap.ir_update !== 1'b1) begin errors++; $display("FAIL ir_updated: got ir=%h iru=%b expected 8/1", tap.ir, tap.ir_update); end
    step(0, 0);
    checks++; if (tap.ir_update !== 1'b0) begin errors++; $display("FAIL ir_strobe_len: got %b expected 0", tap.ir_update); end
  endtask

  task automatic test_user_dr;
    logic [31:0] dout;
    tap.dr_capture_data = 32'hDEAD_BEEF;
    scan_dr(32'hA5A5_A5A5, dout);
    checks++; if (dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL user_capture: got %h expected deadbeef", dout); end
    checks++; if (tap.dr_update !== 1'b1 || tap.dr_update_data !== 32'hA5A5_A5A5)
      begin errors++; $display("FAIL user_update: got dru=%b data=%h expected 1/a5a5a5a5", tap.dr_update, tap.dr_update_data); end
    step(0, 0);
    checks++; if (tap.dr_update !== 1'b0) begin errors++; $display("FAIL user_strobe_len: got %b expected 0", tap.dr_update); end
    load_ir(4'h1);
    checks++; if (tap.ir !== 4'h1) begin errors++; $display("FAIL user_reload_ir: got %h expected 1", tap.ir); end
    scan_dr(32'h0F0F_0F0F, dout);
    checks++; if (dout !== 32'h1234_5679) begin errors++; $display("FAIL idcode_rescan: got %h expected 12345679", dout); end
    checks++; if (tap.dr_update !== 1'b0 || tap.dr_update_data !== 32'hA5A5_A5A5)
      begin errors++; $display("FAIL idcode_no_update: got dru=%b data=%h expected 0/a5a5a5a5", tap.dr_update, tap.dr_update_data); end
  endtask

  task automatic test_bypass;
    logic [3:0] din = 4'b1101;
    logic [3:0] dout;
    load_ir(4'hF);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      dout[i] = tap.tdo;
      step(i == 3, din[i]);
    end
    checks++; if (dout !== 4'b1010) begin errors++; $display("FAIL bypass_delay: got %b expected 1010", dout); end
    step(1, 0); step(0, 0);
    checks++; if (tap.dr_update !== 1'b0 || tap.dr_update_data !== 32'hA5A5_A5A5)
      begin errors++; $display("FAIL bypass_no_update: got dru=%b data=%h expected 0/a5a5a5a5", tap.dr_update, tap.dr_update_data); end
  endtask

  task automatic test_pause;
    logic [31:0] din = 32'h3C96_5AF1;
    logic [31:0] dout;
    load_ir(4'h8);
    tap.dr_capture_data = 32'h1357_9BDF;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 32; i++) begin
      dout[i] = tap.tdo;
      if (i == 9) begin
        step(1, din[i]);
        checks++; if (tap.state !== 4'd1) begin errors++; $display("FAIL pause_ex1: got %0d expected 1", tap.state); end
        for (int k = 0; k < 5; k++) step(0, 1);
        checks++; if (tap.state !== 4'd3 || tap.tdo_en !== 1'b0) begin errors++; $display("FAIL pause_hold: got st=%0d en=%b expected 3/0", tap.state, tap.tdo_en); end
        step(1, 1);
        step(0, 1);
        checks++; if (tap.state !== 4'd2) begin errors++; $display("FAIL pause_resume: got %0d expected 2", tap.state); end
      end else begin
        step(i == 31, din[i]);
      end
    end
    step(1, 0); step(0, 0);
    checks++; if (dout !== 32'h1357_9BDF) begin errors++; $display("FAIL pause_capture: got %h expected 13579bdf", dout); end
    checks++; if (tap.dr_update !== 1'b1 || tap.dr_update_data !== din)
      begin errors++; $display("FAIL pause_update: got dru=%b data=%h expected 1/%h", tap.dr_update, tap.dr_update_data, din); end
  endtask

  task automatic test_tms_reset;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    checks++; if (tap.state !== 4'd15) begin errors++; $display("FAIL tms5_state: got %0d expected 15", tap.state); end
    step(1, 0);
    checks++; if (tap.ir !== 4'h1 || tap.ir_update !== 1'b1) begin errors++; $display("FAIL tlr_force_ir: got ir=%h iru=%b expected 1/1", tap.ir, tap.ir_update); end
    step(1, 0);
    checks++; if (tap.ir_update !== 1'b0) begin errors++; $display("FAIL tlr_no_repulse: got %b expected 0", tap.ir_update); end
    step(0, 0);
  endtask

  task automatic test_sync_reset;
    load_ir(4'h8);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(0, 1);
    checks++; if (tap.dr_update_data === 32'h0) begin errors++; $display("FAIL pre_reset_data: got %h expected nonzero", tap.dr_update_data); end
    RESET = 1'b1;
    step(0, 1);
    RESET = 1'b0;
    checks++; if (tap.state !== 4'd15 || tap.ir !== 4'h1 || tap.dr_update_data !== 32'h0)
      begin errors++; $display("FAIL midshift_reset: got st=%0d ir=%h data=%h expected 15/1/0", tap.state, tap.ir, tap.dr_update_data); end
    step(0, 0);
  endtask

`ifdef JTAG_TRST_EN
  task automatic test_trst;
    logic [31:0] dout;
    load_ir(4'h8);
    tap.dr_capture_data = 32'h0;
    scan_dr(32'h5555_AAAA, dout);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 3; i++) step(0, 1);
    trst = 1'b1;
    step(0, 1);
    trst = 1'b0;
    checks++; if (tap.state !== 4'd15 || tap.ir !== 4'h1 || tap.dr_update_data !== 32'h5555_AAAA)
      begin errors++; $display("FAIL trst_pulse: got st=%0d ir=%h data=%h expected 15/1/5555aaaa", tap.state, tap.ir, tap.dr_update_data); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    RESET = 1'b0;
`ifdef JTAG_TRST_EN
    trst = 1'b0;
`endif
    tap.tms = 1'b0;
    tap.tdi = 1'b0;
    tap.dr_capture_data = '0;
    @(negedge CLK);
    test_reset();
    test_idcode();
    test_ir_load();
    test_user_dr();
    test_bypass();
    test_pause();
    test_tms_reset();
    test_sync_reset();
`ifdef JTAG_TRST_EN
    test_trst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
